fp16_int_converter: RTL



---
 rtl/fpu_pkg.sv | 45 ++++
 rtl/fp16_int_converter_if.sv | 20 ++
 rtl/fp16_int_converter_lzc16.sv | 13 +
 rtl/fp16_int_converter.sv | 93 +++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants, operation codes and stage payload types for the
// integer-to-binary16 converter.
package fpu_pkg;
   localparam int          FP16_EXP_W   = 5;
   localparam int          FP16_MAN_W   = 10;
   localparam int          FP16_BIAS    = 15;
   localparam logic [15:0] FP16_POS_INF = 16'h7C00;
   localparam logic [15:0] FP16_MAX     = 16'h7BFF;

   typedef enum logic [2:0] {
      FPU_ADD = 3'b000,
      FPU_SUB = 3'b001,
      FPU_MUL = 3'b010,
      CVT_I2F = 3'b011,
      CVT_U2F = 3'b100
   } fpu_op_e;

   // captured operand
   typedef struct packed {
      logic        is_signed;
      logic [15:0] data;
   } cvt_in_t;

   // after sign/abs
   typedef struct packed {
      logic        sign;
      logic        zero;
      logic [16:0] mag;
   } cvt_s1_t;

   // after normalize: shifted has its MSB at bit 15, exp is unbiased
   typedef struct packed {
      logic        sign;
      logic        zero;
      logic [3:0]  exp;
      logic [15:0] shifted;
   } cvt_s2_t;

   // packed result and flags
   typedef struct packed {
      logic [15:0] result;
      logic        inexact;
      logic        overflow;
   } cvt_out_t;
endpackage

// File: rtl/fp16_int_converter_if.sv
// Operand/result bundle of the integer-to-binary16 converter.
interface fp16_int_converter_if;
   logic        valid_in;
   logic [15:0] int_in;
   logic        is_signed;
   logic        valid_out;
   logic [15:0] result;
   logic        inexact;
   logic        overflow;
   logic        busy;

   modport master (
      output valid_in, int_in, is_signed,
      input  valid_out, result, inexact, overflow, busy
   );
   modport slave (
      input  valid_in, int_in, is_signed,
      output valid_out, result, inexact, overflow, busy
   );
endinterface

// File: rtl/fp16_int_converter_lzc16.sv
// Combinational 16-bit leading-zero counter; returns 16 for an all-zero word.
module lzc16 (
   input  logic [15:0] a,
   output logic [4:0]  cnt
);
   // scan upward so the highest set bit has the final say
   always_comb begin
      cnt = 5'd16;
      for (int i = 0; i < 16; i++) begin
         if (a[i]) cnt = 5'(15 - i);
      end
   end
endmodule

// File: rtl/fp16_int_converter.sv
// Pipelined 16-bit integer (signed/unsigned) to binary16 converter, RNE.
// Operand capture, sign/abs, normalize, round/pack into the output register.
module fp16_int_converter
   import fpu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   fp16_int_converter_if.slave bus
);
   logic [3:0] vld_pipe_q, vld_pipe_d;
   cvt_in_t    in_q,  in_d;
   cvt_s1_t    s1_q,  s1_d;
   cvt_s2_t    s2_q,  s2_d;
   cvt_out_t   out_q, out_d;
   logic [4:0] lz;

   // valid shift register: [0] capture, [1] sign/abs, [2] normalize, [3] output
   always_comb vld_pipe_d = {vld_pipe_q[2:0], bus.valid_in};

   always_comb begin
      in_d.is_signed = bus.is_signed;
      in_d.data      = bus.int_in;
   end

   // sign/abs: 17-bit magnitude so -32768 maps to +32768
   always_comb begin
      logic [16:0] ext;
      s1_d.sign = in_q.is_signed & in_q.data[15];
      ext       = {s1_d.sign, in_q.data};
      s1_d.mag  = s1_d.sign ? (~ext + 17'd1) : ext;
      s1_d.zero = (s1_d.mag == 17'd0);
   end

   lzc16 u_lzc (.a(s1_q.mag[15:0]), .cnt(lz));

   // normalize: MSB to bit 15, exponent 15 - lz (don't-care for zero)
   always_comb begin
      s2_d.sign    = s1_q.sign;
      s2_d.zero    = s1_q.zero;
      s2_d.shifted = 16'(s1_q.mag << lz);
      s2_d.exp     = 4'(5'd15 - lz);
   end

   // round to nearest even and pack; saturate to +inf on exponent overflow
   always_comb begin
      logic [9:0]  frac;
      logic        guard, sticky, rnd;
      logic [10:0] frac_r;
      logic [5:0]  exp_b;
      frac   = s2_q.shifted[14:5];
      guard  = s2_q.shifted[4];
      sticky = |s2_q.shifted[3:0];
      rnd    = guard & (sticky | frac[0]);
      frac_r = {1'b0, frac} + 11'(rnd);
      exp_b  = 6'(s2_q.exp) + 6'(FP16_BIAS) + 6'(frac_r[10]);
      out_d  = '0;
      if (s2_q.zero) begin
         out_d = '0;
      end else if (exp_b >= 6'd31) begin
         out_d.result   = {s2_q.sign, FP16_POS_INF[14:0]};
         out_d.overflow = 1'b1;
      end else begin
         out_d.result  = {s2_q.sign, exp_b[4:0], frac_r[9:0]};
         out_d.inexact = guard | sticky;
      end
   end

   // stage registers load only behind a valid stage to avoid idle toggling
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         in_q       <= '0;
         s1_q       <= '0;
         s2_q       <= '0;
         out_q      <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         if (bus.valid_in)  in_q  <= in_d;
         if (vld_pipe_q[0]) s1_q  <= s1_d;
         if (vld_pipe_q[1]) s2_q  <= s2_d;
         if (vld_pipe_q[2]) out_q <= out_d;
      end
   end

   // outputs straight from flops
   always_comb begin
      bus.valid_out = vld_pipe_q[3];
      bus.result    = out_q.result;
      bus.inexact   = out_q.inexact;
      bus.overflow  = out_q.overflow;
      bus.busy      = |vld_pipe_q;
   end
endmodule
